// File: rtl/ir_line_calibrator_if.sv
// ir_line_calibrator_if: sensor readings, command pulses and classification results of the IR line calibrator
interface ir_line_calibrator_if #(
    parameter int NCH = 8,
    parameter int TW  = 17
) ();
    logic [NCH*TW-1:0]          ttd;
    logic                       sample_valid;
    logic                       cap_a;
    logic                       cap_b;
    logic                       recal;
    logic                       busy;
    logic                       cal_done;
    logic                       cal_fault;
    logic [NCH-1:0]             line_det;
    logic [$clog2(NCH+1)-1:0]   line_cnt;
    logic                       det_valid;

    modport master (
        output ttd, sample_valid, cap_a, cap_b, recal,
        input  busy, cal_done, cal_fault, line_det, line_cnt, det_valid
    );

    modport slave (
        input  ttd, sample_valid, cap_a, cap_b, recal,
        output busy, cal_done, cal_fault, line_det, line_cnt, det_valid
    );
endinterface

// File: rtl/ir_line_calibrator.sv
// ir_line_calibrator: two-surface per-channel threshold calibration and line classification; define IR_HYST_EN for hysteresis
module ir_line_calibrator #(
    parameter int NCH          = 8,
    parameter int TW           = 17,
    parameter int AVG_LOG2     = 2,
    parameter int MIN_CONTRAST = 16,
    parameter int HYST         = 8
) (
    input logic                 WF_CLK,
    input logic                 reset,
    ir_line_calibrator_if.slave bus
);
    localparam int CW = $clog2(NCH+1);
    localparam int AW = TW + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] LAST = NW'(2**AVG_LOG2 - 1);
    localparam logic [TW-1:0] MC = TW'(MIN_CONTRAST);
`ifdef IR_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif
    localparam logic [TW-1:0] HB = HYST_ON ? TW'(HYST) : '0;

    typedef enum logic [2:0] {UNCAL, CAP_A, WAIT_B, CAP_B, EVAL, CAL} state_t;

    state_t          state, next;
    logic [NW-1:0]   cnt;
    logic [AW-1:0]   acc [NCH];
    logic [AW-1:0]   sum [NCH];
    logic [TW-1:0]   avg_a [NCH];
    logic [TW-1:0]   avg_b [NCH];
    logic [TW-1:0]   thr [NCH];
    logic [TW-1:0]   mid [NCH];
    logic [TW-1:0]   hi [NCH];
    logic [TW-1:0]   lo [NCH];
    logic [TW:0]     hi_w [NCH];
    logic [TW-1:0]   rd [NCH];
    logic [NCH-1:0]  line_det, det;
    logic [CW-1:0]   line_cnt, cnt_det;
    logic            det_valid, cal_fault, last, fault, cap, clr, in_cal;

    assign bus.busy      = state == CAP_A || state == CAP_B || state == EVAL;
    assign bus.cal_done  = state == CAL;
    assign bus.cal_fault = cal_fault;
    assign bus.line_det  = line_det;
    assign bus.line_cnt  = line_cnt;
    assign bus.det_valid = det_valid;

    // per-channel sums, averages, midpoint, contrast check and classification
    always_comb begin
        fault   = 1'b0;
        cnt_det = '0;
        for (int i = 0; i < NCH; i++) begin
            rd[i]    = bus.ttd[i*TW +: TW];
            sum[i]   = acc[i] + AW'(rd[i]);
            avg_b[i] = TW'(acc[i] >> AVG_LOG2);
            mid[i]   = TW'(({1'b0, avg_a[i]} + {1'b0, avg_b[i]}) >> 1);
            fault    = fault | (((avg_a[i] > avg_b[i]) ? avg_a[i] - avg_b[i] : avg_b[i] - avg_a[i]) < MC);
            hi_w[i]  = {1'b0, thr[i]} + {1'b0, HB};
            hi[i]    = hi_w[i][TW] ? '1 : hi_w[i][TW-1:0];
            lo[i]    = (thr[i] < HB) ? '0 : thr[i] - HB;
            det[i]   = (rd[i] > hi[i]) ? 1'b1 : (HYST_ON && rd[i] >= lo[i]) ? line_det[i] : 1'b0;
            cnt_det  = cnt_det + CW'(det[i]);
        end
    end

    // next-state selection with recal > cap_a > cap_b priority
    always_comb begin
        next = state;
        last = bus.sample_valid && cnt == LAST;
        if (bus.recal)
            next = UNCAL;
        else
            case (state)
                UNCAL:   next = bus.cap_a ? CAP_A : UNCAL;
                CAP_A:   next = last ? WAIT_B : CAP_A;
                WAIT_B:  next = bus.cap_a ? CAP_A : bus.cap_b ? CAP_B : WAIT_B;
                CAP_B:   next = last ? EVAL : CAP_B;
                EVAL:    next = fault ? UNCAL : CAL;
                CAL:     next = bus.cap_a ? CAP_A : CAL;
                default: next = UNCAL;
            endcase
    end

    // state register
    always_ff @(posedge WF_CLK) begin
        if (reset)
            state <= UNCAL;
        else
            state <= next;
    end

    assign cap    = (state == CAP_A || state == CAP_B) && !bus.recal;
    assign clr    = bus.recal || (next != state && (next == CAP_A || next == CAP_B)) || (state == CAP_A && next == WAIT_B);
    assign in_cal = state == CAL && next == CAL;

    // accumulation, averages, thresholds, fault flag and registered detection outputs
    always_ff @(posedge WF_CLK) begin
        if (reset) begin
            cnt       <= '0;
            cal_fault <= 1'b0;
            line_det  <= '0;
            line_cnt  <= '0;
            det_valid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc[i]   <= '0;
                avg_a[i] <= '0;
                thr[i]   <= '0;
            end
        end else begin
            cnt       <= clr ? '0 : (cap && bus.sample_valid) ? cnt + NW'(1) : cnt;
            cal_fault <= bus.recal ? 1'b0 : (state == EVAL) ? fault : (next == CAP_A) ? 1'b0 : cal_fault;
            det_valid <= in_cal && bus.sample_valid;
            line_det  <= !in_cal ? '0 : bus.sample_valid ? det : line_det;
            line_cnt  <= !in_cal ? '0 : bus.sample_valid ? cnt_det : line_cnt;
            for (int i = 0; i < NCH; i++) begin
                acc[i]   <= clr ? '0 : (cap && bus.sample_valid) ? sum[i] : acc[i];
                avg_a[i] <= (state == CAP_A && next == WAIT_B) ? TW'(sum[i] >> AVG_LOG2) : avg_a[i];
                thr[i]   <= (state == EVAL && next == CAL) ? mid[i] : thr[i];
            end
        end
    end
endmodule
